// File: rtl/sync_fifo_flags.sv
// Purpose : single-clock FIFO with occupancy count, almost-full/almost-empty
//           thresholds, sticky overflow/underflow flags, optional FWFT read.
// Latency : 1 cycle write-to-flags; FWFT=0 read data 1 cycle after the read
//           edge; FWFT=1 head visible 1 cycle after a write into empty.
// Backpr. : writes are refused while full and reads while empty. A refused
//           request only raises overflow/underflow and changes no other state.
//
// Ports:
//   clk, reset         single rising-edge clock, synchronous active-high reset
//   write_en/_data     push request and payload (accepted iff !full)
//   read_en            pop request (accepted iff !empty)
//   clear_err          clears the sticky error flags (a new error event wins)
//   read_data          registered read (FWFT=0) or head entry (FWFT=1)
//   full/empty/almost_full/almost_empty/count   decoded from registered count
//   overflow/underflow sticky error flags
module sync_fifo_flags #(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = DEPTH - 2,
  parameter int AE_THRESH = 2
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     write_en,
  input  logic [WIDTH-1:0]         write_data,
  input  logic                     read_en,
  input  logic                     clear_err,
  output logic [WIDTH-1:0]         read_data,
  output logic                     full,
  output logic                     empty,
  output logic                     almost_full,
  output logic                     almost_empty,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     underflow
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int CW   = ADDR + 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
  localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);
  localparam logic [CW-1:0] ONE_C   = CW'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [ADDR:0]    wr_ptr;
  logic [ADDR:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic             overflow_q;
  logic             underflow_q;
  logic             wr_acc;
  logic             rd_acc;

  // Status is decoded purely from the registered count, so no input
  // reaches an output combinationally.
  assign full         = (count_q == DEPTH_C);
  assign empty        = (count_q == '0);
  assign almost_full  = (count_q >= AF_C);
  assign almost_empty = (count_q <= AE_C);
  assign count        = count_q;
  assign overflow     = overflow_q;
  assign underflow    = underflow_q;

  // Acceptance uses pre-edge full/empty: a write while full is refused even
  // if a read is accepted on the same edge.
  assign wr_acc = write_en && !full;
  assign rd_acc = read_en && !empty;

  // Storage carries no reset; stale contents are never observable because
  // the pointers and count are cleared.
  always_ff @(posedge clk) begin
    if (!reset && wr_acc) begin
      mem[wr_ptr[ADDR-1:0]] <= write_data;
    end
  end

  // Pointers are ADDR+1 bits and wrap naturally modulo 2*DEPTH. The count is
  // kept as its own register (always equal to wr_ptr - rd_ptr), so full and
  // empty never depend on the pointer MSBs.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ONE_C;
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ONE_C;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count_q <= count_q + ONE_C;
        2'b01:   count_q <= count_q - ONE_C;
        default: count_q <= count_q;
      endcase
    end
  end

  // Sticky errors: a fresh event on the same edge as clear_err keeps the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_q  <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      if (write_en && full) begin
        overflow_q <= 1'b1;
      end else if (clear_err) begin
        overflow_q <= 1'b0;
      end
      if (read_en && empty) begin
        underflow_q <= 1'b1;
      end else if (clear_err) begin
        underflow_q <= 1'b0;
      end
    end
  end

  generate
    if (FWFT != 0) begin : g_fwft
      // Head entry is presented whenever the FIFO holds data; read_en pops it.
      assign read_data = empty ? '0 : mem[rd_ptr[ADDR-1:0]];
    end else begin : g_std
      logic [WIDTH-1:0] rd_data_q;

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_data_q <= '0;
        end else if (rd_acc) begin
          rd_data_q <= mem[rd_ptr[ADDR-1:0]];
        end
      end

      assign read_data = rd_data_q;
    end
  endgenerate

endmodule

// File: tb/tb_sync_fifo_flags.sv
// Bench for sync_fifo_flags: a standard-read and an FWFT instance share one
// stimulus stream and are both compared against a queue-based model, plus a
// table of hand-derived vectors and targeted corner-case sequences.
module tb_sync_fifo_flags;

  localparam int DEPTH = 8;
  localparam int WIDTH = 8;
  localparam int AFT   = 6;
  localparam int AET   = 2;

  logic             clk = 1'b0;
  logic             reset;
  logic             write_en;
  logic [WIDTH-1:0] write_data;
  logic             read_en;
  logic             clear_err;

  logic [WIDTH-1:0] rd0, rd1;
  logic             full0, empty0, af0, ae0, ovf0, unf0;
  logic             full1, empty1, af1, ae1, ovf1, unf1;
  logic [3:0]       cnt0, cnt1;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [WIDTH-1:0] q[$];
  logic             m_ovf, m_unf;
  logic [WIDTH-1:0] m_rd0;

  always #5 clk = ~clk;

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(0),
                    .AF_THRESH(AFT), .AE_THRESH(AET)) dut0 (
    .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .clear_err(clear_err), .read_data(rd0),
    .full(full0), .empty(empty0), .almost_full(af0), .almost_empty(ae0),
    .count(cnt0), .overflow(ovf0), .underflow(unf0));

  sync_fifo_flags #(.DEPTH(DEPTH), .WIDTH(WIDTH), .FWFT(1),
                    .AF_THRESH(AFT), .AE_THRESH(AET)) dut1 (
    .clk(clk), .reset(reset), .write_en(write_en), .write_data(write_data),
    .read_en(read_en), .clear_err(clear_err), .read_data(rd1),
    .full(full1), .empty(empty1), .almost_full(af1), .almost_empty(ae1),
    .count(cnt1), .overflow(ovf1), .underflow(unf1));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Model update from the pre-edge state, following the acceptance rules.
  task automatic model_edge(input logic rst, input logic we, input logic [7:0] wd,
                            input logic re, input logic ce);
    bit was_full, was_empty;
    if (rst) begin
      q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
      m_rd0 = '0;
    end else begin
      was_full  = (q.size() == DEPTH);
      was_empty = (q.size() == 0);
      if (re && !was_empty) m_rd0 = q.pop_front();
      if (we && !was_full) q.push_back(wd);
      if (we && was_full) m_ovf = 1'b1;
      else if (ce)        m_ovf = 1'b0;
      if (re && was_empty) m_unf = 1'b1;
      else if (ce)         m_unf = 1'b0;
    end
  endtask

  task automatic check_model();
    int n;
    logic [7:0] head;
    n    = q.size();
    head = (n > 0) ? q[0] : 8'h00;
    chk("count0", 32'(cnt0), 32'(n));
    chk("count1", 32'(cnt1), 32'(n));
    chk("full0", 32'(full0), 32'(n == DEPTH));
    chk("empty0", 32'(empty0), 32'(n == 0));
    chk("afull0", 32'(af0), 32'(n >= AFT));
    chk("aempty0", 32'(ae0), 32'(n <= AET));
    chk("full1", 32'(full1), 32'(n == DEPTH));
    chk("empty1", 32'(empty1), 32'(n == 0));
    chk("ovf0", 32'(ovf0), 32'(m_ovf));
    chk("unf0", 32'(unf0), 32'(m_unf));
    chk("ovf1", 32'(ovf1), 32'(m_ovf));
    chk("unf1", 32'(unf1), 32'(m_unf));
    chk("rdata_std", 32'(rd0), 32'(m_rd0));
    chk("rdata_fwft", 32'(rd1), 32'(head));
  endtask

  // One clock: drive inputs, take the edge, then sample 1 time unit later.
  task automatic step(input logic rst, input logic we, input logic [7:0] wd,
                      input logic re, input logic ce);
    reset      = rst;
    write_en   = we;
    write_data = wd;
    read_en    = re;
    clear_err  = ce;
    @(posedge clk);
    model_edge(rst, we, wd, re, ce);
    #1;
    check_model();
  endtask

  typedef struct {
    logic       rst, we;
    logic [7:0] wd;
    logic       re, ce;
    logic [3:0] cnt;
    logic       full, empty, af, ae, ovf, unf;
    logic [7:0] rd0, rd1;
  } vec_t;

  vec_t tbl[$];

  initial begin
    vec_t v;
    reset = 1'b1; write_en = 1'b0; write_data = '0; read_en = 1'b0; clear_err = 1'b0;
    q.delete(); m_ovf = 1'b0; m_unf = 1'b0; m_rd0 = '0;

    // rst we wd re ce | cnt full empty af ae ovf unf rd0 rd1
    tbl.push_back('{1,0,8'h00,0,0, 0,0,1,0,1,0,0,8'h00,8'h00});
    tbl.push_back('{0,1,8'h01,0,0, 1,0,0,0,1,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h02,0,0, 2,0,0,0,1,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h03,0,0, 3,0,0,0,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h04,0,0, 4,0,0,0,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h05,0,0, 5,0,0,0,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h06,0,0, 6,0,0,1,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h07,0,0, 7,0,0,1,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'h08,0,0, 8,1,0,1,0,0,0,8'h00,8'h01});
    tbl.push_back('{0,1,8'hFF,0,0, 8,1,0,1,0,1,0,8'h00,8'h01});
    tbl.push_back('{0,0,8'h00,1,0, 7,0,0,1,0,1,0,8'h01,8'h02});
    tbl.push_back('{0,0,8'h00,1,0, 6,0,0,1,0,1,0,8'h02,8'h03});
    tbl.push_back('{0,0,8'h00,1,0, 5,0,0,0,0,1,0,8'h03,8'h04});
    tbl.push_back('{0,0,8'h00,1,0, 4,0,0,0,0,1,0,8'h04,8'h05});
    tbl.push_back('{0,0,8'h00,1,0, 3,0,0,0,0,1,0,8'h05,8'h06});
    tbl.push_back('{0,0,8'h00,1,0, 2,0,0,0,1,1,0,8'h06,8'h07});
    tbl.push_back('{0,0,8'h00,1,0, 1,0,0,0,1,1,0,8'h07,8'h08});
    tbl.push_back('{0,0,8'h00,1,0, 0,0,1,0,1,1,0,8'h08,8'h00});
    tbl.push_back('{0,0,8'h00,1,0, 0,0,1,0,1,1,1,8'h08,8'h00});
    tbl.push_back('{0,0,8'h00,0,1, 0,0,1,0,1,0,0,8'h08,8'h00});

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      step(v.rst, v.we, v.wd, v.re, v.ce);
      chk($sformatf("tbl%0d_count", i), 32'(cnt0), 32'(v.cnt));
      chk($sformatf("tbl%0d_full", i), 32'(full0), 32'(v.full));
      chk($sformatf("tbl%0d_empty", i), 32'(empty0), 32'(v.empty));
      chk($sformatf("tbl%0d_afull", i), 32'(af0), 32'(v.af));
      chk($sformatf("tbl%0d_aempty", i), 32'(ae0), 32'(v.ae));
      chk($sformatf("tbl%0d_ovf", i), 32'(ovf0), 32'(v.ovf));
      chk($sformatf("tbl%0d_unf", i), 32'(unf0), 32'(v.unf));
      chk($sformatf("tbl%0d_rd_std", i), 32'(rd0), 32'(v.rd0));
      chk($sformatf("tbl%0d_rd_fwft", i), 32'(rd1), 32'(v.rd1));
    end

    // Steady state at count=4 with simultaneous read/write across wraps.
    for (int i = 0; i < 4; i++) step(0, 1, 8'(8'h40 + i), 0, 0);
    for (int i = 0; i < 36; i++) begin
      step(0, 1, 8'(8'h44 + i), 1, 0);
      chk("stream_order", 32'(rd0), 32'(8'h40 + i));
    end
    chk("stream_count", 32'(cnt0), 32'd4);

    // FWFT head presentation from empty.
    step(1, 0, 8'h00, 0, 0);
    step(0, 1, 8'hA5, 0, 0);
    chk("fwft_head", 32'(rd1), 32'h0A5);
    chk("fwft_nonempty", 32'(empty1), 32'd0);
    step(0, 0, 8'h00, 1, 0);
    chk("fwft_pop_empty", 32'(empty1), 32'd1);
    chk("fwft_pop_data", 32'(rd1), 32'd0);

    // Overflow clear, then clear_err colliding with a new overflow event.
    for (int i = 0; i < DEPTH; i++) step(0, 1, 8'(8'h10 + i), 0, 0);
    step(0, 1, 8'hEE, 0, 0);
    chk("ovf_set", 32'(ovf0), 32'd1);
    step(0, 0, 8'h00, 0, 1);
    chk("ovf_cleared", 32'(ovf0), 32'd0);
    step(0, 1, 8'hEE, 0, 1);
    chk("ovf_event_wins", 32'(ovf0), 32'd1);

    // Reset mid-stream with concurrent requests discards everything.
    step(1, 0, 8'h00, 0, 0);
    for (int i = 0; i < 5; i++) step(0, 1, 8'(8'h70 + i), 0, 0);
    step(1, 1, 8'hBB, 1, 0);
    chk("rst_count", 32'(cnt0), 32'd0);
    chk("rst_empty", 32'(empty0), 32'd1);
    chk("rst_aempty", 32'(ae0), 32'd1);
    chk("rst_rdata", 32'(rd0), 32'd0);
    step(0, 1, 8'h3C, 0, 0);
    step(0, 0, 8'h00, 1, 0);
    chk("post_rst_data", 32'(rd0), 32'h03C);
    chk("post_rst_empty", 32'(empty0), 32'd1);

    // Randomised traffic with shifting write/read bias to reach both ends.
    begin
      int wp;
      wp = 50;
      for (int i = 0; i < 3000; i++) begin
        if (i % 250 == 0) wp = $urandom_range(10, 90);
        step(($urandom % 300) == 0,
             $urandom_range(0, 99) < wp,
             8'($urandom),
             $urandom_range(0, 99) < (100 - wp),
             ($urandom % 16) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
